simple_circuit_pipe: RTL

Clocked, parametrised successor to the combinational teaching circuit: computes W1 = A & B, D = W1 | C, E = ~C bitwise over WIDTH-bit operands. Results pass through a LATENCY-stage pipeline with per-stage valid bits and valid/ready flow control. Each stage collapses bubbles. The block replaces gate-delay modelling with cycle-accurate latency in the Chapter 5 sequential examples and their testbenches.

---
 rtl/simple_circuit_pkg.sv | 21 ++
 rtl/simple_circuit_pipe_if.sv | 40 ++++
 rtl/simple_circuit_stage.sv | 28 ++
 rtl/simple_circuit_pipe.sv | 83 ++++++++
 4 files changed

// File: rtl/simple_circuit_pkg.sv
// Shared types and constants for the simple_circuit pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef SIMPLE_CIRCUIT_PKG_SV
`define SIMPLE_CIRCUIT_PKG_SV

// Result record {w1, d, e}, sized by the caller's operand width.
`define SIMPLE_CIRCUIT_RES_T(W) struct packed { logic [(W)-1:0] w1; logic [(W)-1:0] d; logic [(W)-1:0] e; }

package simple_circuit_pkg;
    localparam int COUNT_W     = 16;
    localparam int DEF_WIDTH   = 1;
    localparam int DEF_LATENCY = 2;

    // Flattened bit width of one result record.
    function automatic int res_bits(input int width);
        return 3 * width;
    endfunction
endpackage

`endif

// File: rtl/simple_circuit_pipe_if.sv
// Operand/result handshake bundle for simple_circuit_pipe; count exists only with SIMPLE_CIRCUIT_PIPE_COUNT_EN.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry valid/ready flow control in each direction.
interface simple_circuit_pipe_if #(
    parameter int WIDTH = simple_circuit_pkg::DEF_WIDTH
);
    import simple_circuit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] w1;
`ifdef SIMPLE_CIRCUIT_PIPE_COUNT_EN
    logic [COUNT_W-1:0] count;
`endif

    // Producer/consumer side: drives operands and out_ready.
    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, d, e, w1
`ifdef SIMPLE_CIRCUIT_PIPE_COUNT_EN
        , input count
`endif
    );

    // Pipeline side.
    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, d, e, w1
`ifdef SIMPLE_CIRCUIT_PIPE_COUNT_EN
        , output count
`endif
    );
endinterface

// File: rtl/simple_circuit_stage.sv
// One pipeline slot: valid bit plus data register, loads whenever it is empty or downstream advances.
// Latency: 1 cycle.
// Backpressure: adv = !vld | dn_adv, so an empty slot absorbs data while later slots stall.
module simple_circuit_stage #(
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld,
    input  logic [DW-1:0] up_dat,
    input  logic          dn_adv,
    output logic          adv,
    output logic          vld,
    output logic [DW-1:0] dat
);
    assign adv = !vld | dn_adv;

    // Load from upstream on advance, otherwise hold; reset empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (adv) begin
            vld <= up_vld;
            dat <= up_dat;
        end
    end
endmodule

// File: rtl/simple_circuit_pipe.sv
// Computes w1 = a & b, d = w1 | c, e = ~c and carries results through a LATENCY-deep bubble-collapsing pipeline; SIMPLE_CIRCUIT_PIPE_COUNT_EN adds a 16-bit output-transfer counter.
// Latency: LATENCY cycles from presentation to out_valid when unstalled; one result per cycle sustained.
// Backpressure: in_ready is low only when every stage is full and out_ready is low.
module simple_circuit_pipe
    import simple_circuit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,   // >= 1
    parameter int LATENCY = DEF_LATENCY  // >= 1
) (
    input  logic                clk,
    input  logic                rst,
    simple_circuit_pipe_if.slave bus
);
    typedef `SIMPLE_CIRCUIT_RES_T(WIDTH) res_t;
    localparam int DW = res_bits(WIDTH);

    res_t            in_res;
    res_t            out_res;
    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] adv;
    logic [DW-1:0]   stage_dat [LATENCY];

    // The only real logic: evaluated straight from the operands ahead of stage 0.
    always_comb begin
        in_res    = '0;
        in_res.w1 = bus.a & bus.b;
        in_res.d  = (bus.a & bus.b) | bus.c;
        in_res.e  = ~bus.c;
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic          up_vld;
        logic [DW-1:0] up_dat;
        logic          dn_adv;

        if (s == 0) begin : g_first
            assign up_vld = bus.in_valid;
            assign up_dat = DW'(in_res);
        end else begin : g_mid
            assign up_vld = v[s-1];
            assign up_dat = stage_dat[s-1];
        end

        if (s == LATENCY - 1) begin : g_last
            assign dn_adv = bus.out_ready;
        end else begin : g_inner
            assign dn_adv = adv[s+1];
        end

        simple_circuit_stage #(.DW(DW)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .up_vld (up_vld),
            .up_dat (up_dat),
            .dn_adv (dn_adv),
            .adv    (adv[s]),
            .vld    (v[s]),
            .dat    (stage_dat[s])
        );
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v[LATENCY-1];
    assign out_res       = res_t'(stage_dat[LATENCY-1]);
    assign bus.d         = out_res.d;
    assign bus.e         = out_res.e;
    assign bus.w1        = out_res.w1;

`ifdef SIMPLE_CIRCUIT_PIPE_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    // Count output transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.count = count_q;
`endif
endmodule
